// File: rtl/mccomp.sv
// mccomp: multi-cycle MIPS-subset computer, a CPU core plus one unified
// instruction/data memory (U_DM).
//
// Ports:
//   clk      - system clock; all state updates on the rising edge
//   rstn     - synchronous reset, active HIGH despite the name
//   reg_sel  - debug register index
//   reg_data - combinational GPR[reg_sel]; 0 when reg_sel = 0
//
// Parameters:
//   MEM_WORDS - memory depth in 32-bit words (power of two; addresses wrap)
//   RESET_PC  - PC loaded on reset
//
// Optional feature: define MCCOMP_JAL_EN to add jal and jr. Without it both
// decode as undefined instructions and have no architectural effect.

module mccomp_mem #(
    parameter int unsigned MEM_WORDS = 128
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] idx,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);
    // Never reset; the program image is preloaded externally.
    logic [31:0] dmem [0:MEM_WORDS-1];

    assign rdata = dmem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            dmem[idx] <= wdata;
        end
    end
endmodule

module mccomp #(
    parameter int unsigned MEM_WORDS = 128,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL  = 6'h02, F_JR  = 6'h08, F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25, F_NOR  = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_e;

    state_e      state_q, state_d;
    logic [31:0] PC, instr;
    logic [31:0] a_q, b_q, alu_out_q, mdr_q;
    logic [31:0] gpr [0:31];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] sext_imm, alu_b, alu_res, mem_rdata, wb_data;
    logic [4:0]  wb_dst;
    logic        is_r, is_ialu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;
    logic        is_jump, is_valid, zext, mem_we;
    logic [AW-1:0] mem_idx;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];
    assign sext_imm = {{16{imm[15]}}, imm};

    assign reg_data = (reg_sel == 5'd0) ? 32'd0 : gpr[reg_sel];

    // Decode
    always_comb begin
        is_r    = 1'b0;
        is_jr   = 1'b0;
        is_jal  = 1'b0;
        if (op == OP_RTYPE) begin
            case (funct)
                F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
                F_NOR, F_SLT, F_SLTU, F_SLL, F_SRL: is_r = 1'b1;
                default: is_r = 1'b0;
            endcase
        end
        is_ialu = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ANDI) ||
                  (op == OP_ORI)  || (op == OP_SLTI)  || (op == OP_LUI);
        is_lw   = (op == OP_LW);
        is_sw   = (op == OP_SW);
        is_beq  = (op == OP_BEQ);
        is_bne  = (op == OP_BNE);
        is_j    = (op == OP_J);
`ifdef MCCOMP_JAL_EN
        is_jal  = (op == OP_JAL);
        is_jr   = (op == OP_RTYPE) && (funct == F_JR);
`else
        is_jal  = 1'b0;
        is_jr   = 1'b0;
`endif
        is_jump  = is_j || is_jal || is_jr;
        is_valid = is_r || is_ialu || is_lw || is_sw || is_beq || is_bne || is_jump;
        zext     = (op == OP_ANDI) || (op == OP_ORI);
    end

    // ALU; lw/sw fall through to the add default for address generation
    always_comb begin
        alu_b   = is_r ? b_q : (zext ? {16'h0, imm} : sext_imm);
        alu_res = a_q + alu_b;
        if (is_r) begin
            case (funct)
                F_SUB, F_SUBU: alu_res = a_q - alu_b;
                F_AND:         alu_res = a_q & alu_b;
                F_OR:          alu_res = a_q | alu_b;
                F_NOR:         alu_res = ~(a_q | alu_b);
                F_SLT:         alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
                F_SLTU:        alu_res = {31'd0, a_q < alu_b};
                F_SLL:         alu_res = b_q << shamt;
                F_SRL:         alu_res = b_q >> shamt;
                default:       alu_res = a_q + alu_b;
            endcase
        end else begin
            case (op)
                OP_ANDI: alu_res = a_q & alu_b;
                OP_ORI:  alu_res = a_q | alu_b;
                OP_SLTI: alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
                OP_LUI:  alu_res = {imm, 16'h0};
                default: alu_res = a_q + alu_b;
            endcase
        end
    end

    assign wb_dst  = is_r ? rd : rt;
    assign wb_data = is_lw ? mdr_q : alu_out_q;

    // Memory is shared: fetch uses PC, data accesses use ALUOut.
    assign mem_idx = (state_q == S_IF) ? PC[AW+1:2] : alu_out_q[AW+1:2];
    // Reset suppresses an in-flight store.
    assign mem_we  = (state_q == S_MEM) && is_sw && !rstn;

    mccomp_mem #(
        .MEM_WORDS(MEM_WORDS)
    ) U_DM (
        .clk  (clk),
        .we   (mem_we),
        .idx  (mem_idx),
        .wdata(b_q),
        .rdata(mem_rdata)
    );

    // Jumps do their work in S_ID, then take one idle pass through S_EX.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID:    state_d = is_valid ? S_EX : S_IF;
            S_EX: begin
                if (is_lw || is_sw)          state_d = S_MEM;
                else if (is_r || is_ialu)    state_d = S_WB;
                else                         state_d = S_IF;
            end
            S_MEM:   state_d = is_lw ? S_WB : S_IF;
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= S_IF;
            PC        <= RESET_PC;
            instr     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IF: begin
                    instr <= mem_rdata;
                    PC    <= PC + 32'd4;
                end
                S_ID: begin
                    a_q       <= gpr[rs];
                    b_q       <= gpr[rt];
                    alu_out_q <= PC + {sext_imm[29:0], 2'b00};
                    if (is_j) begin
                        PC <= {PC[31:28], instr[25:0], 2'b00};
                    end
`ifdef MCCOMP_JAL_EN
                    if (is_jal) begin
                        PC      <= {PC[31:28], instr[25:0], 2'b00};
                        gpr[31] <= PC;
                    end
                    if (is_jr) begin
                        PC <= gpr[rs];
                    end
`endif
                end
                S_EX: begin
                    if (is_r || is_ialu || is_lw || is_sw) begin
                        alu_out_q <= alu_res;
                    end else if ((is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q))) begin
                        PC <= alu_out_q;
                    end
                end
                S_MEM: begin
                    if (is_lw) begin
                        mdr_q <= mem_rdata;
                    end
                end
                S_WB: begin
                    if (wb_dst != 5'd0) begin
                        gpr[wb_dst] <= wb_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mccomp.sv
// tb_mccomp: directed-vector bench for mccomp. Programs are written straight
// into U_DM.dmem; expected values are hand-computed from the instruction
// semantics and the per-class cycle counts.

module tb_mccomp;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [4:0]  reg_sel = 5'd0;
    logic [31:0] reg_data;

    int n_checks = 0;
    int n_pass   = 0;

    mccomp dut (
        .clk     (clk),
        .rstn    (rstn),
        .reg_sel (reg_sel),
        .reg_data(reg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {6'h00, rs, rt, rd, shamt, funct};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_reg(input string tag, input logic [4:0] sel, input logic [31:0] exp);
        reg_sel = sel;
        #1;
        check(tag, reg_data, exp);
    endtask

    // Advance n rising edges, then sit 1ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) dut.U_DM.dmem[i] = 32'd0;
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        dut.U_DM.dmem[addr] = w;
    endtask

    // Hold reset over two edges, release; the next edge is the first fetch.
    task automatic do_reset();
        rstn = 1'b1;
        tick(2);
        rstn = 1'b0;
    endtask

    logic [31:0] beq_self;

    initial begin
        beq_self = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);

        // ---------------- reset + ALU sequence ----------------
        clear_mem();
        put(0,  enc_i(6'h08, 5'd0, 5'd1, 16'd5));           // addi $1,$0,5
        put(1,  enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));        // addi $2,$0,-3
        put(2,  enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));      // addu $3,$1,$2
        put(3,  enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h2A));      // slt  $4,$2,$1
        put(4,  enc_i(6'h0D, 5'd0, 5'd5, 16'hFFFF));        // ori  $5,$0,0xFFFF
        put(5,  enc_r(5'd2, 5'd1, 5'd8, 5'd0, 6'h2B));      // sltu $8,$2,$1
        put(6,  enc_r(5'd1, 5'd2, 5'd9, 5'd0, 6'h22));      // sub  $9,$1,$2
        put(7,  enc_i(6'h0F, 5'd0, 5'd10, 16'h1234));       // lui  $10,0x1234
        put(8,  enc_i(6'h0C, 5'd2, 5'd11, 16'hFFF0));       // andi $11,$2,0xFFF0
        put(9,  enc_r(5'd1, 5'd0, 5'd12, 5'd0, 6'h27));     // nor  $12,$1,$0
        put(10, enc_r(5'd0, 5'd1, 5'd13, 5'd4, 6'h00));     // sll  $13,$1,4
        put(11, enc_r(5'd0, 5'd2, 5'd14, 5'd28, 6'h02));    // srl  $14,$2,28
        put(12, enc_r(5'd1, 5'd10, 5'd15, 5'd0, 6'h25));    // or   $15,$1,$10
        put(13, enc_r(5'd2, 5'd5, 5'd16, 5'd0, 6'h24));     // and  $16,$2,$5
        put(14, enc_i(6'h0A, 5'd2, 5'd17, 16'hFFFE));       // slti $17,$2,-2
        put(15, beq_self);
        rstn = 1'b1;
        tick(2);
        check("reset_pc", dut.PC, 32'h0);
        check("reset_instr", dut.instr, 32'h0);
        rstn = 1'b0;
        tick(1);
        check("fetch_pc", dut.PC, 32'h4);
        check("fetch_instr", dut.instr, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        tick(10);                                           // edge 11
        check_reg("addu_before_wb", 5'd3, 32'd0);
        tick(1);                                            // edge 12
        check_reg("addu_after_wb", 5'd3, 32'd2);
        tick(60);
        check_reg("gpr1_addi", 5'd1, 32'd5);
        check_reg("gpr2_addi_neg", 5'd2, 32'hFFFF_FFFD);
        check_reg("gpr4_slt", 5'd4, 32'd1);
        check_reg("gpr5_ori_zext", 5'd5, 32'h0000_FFFF);
        check_reg("gpr8_sltu", 5'd8, 32'd0);
        check_reg("gpr9_sub", 5'd9, 32'd8);
        check_reg("gpr10_lui", 5'd10, 32'h1234_0000);
        check_reg("gpr11_andi", 5'd11, 32'h0000_FFF0);
        check_reg("gpr12_nor", 5'd12, 32'hFFFF_FFFA);
        check_reg("gpr13_sll", 5'd13, 32'h0000_0050);
        check_reg("gpr14_srl", 5'd14, 32'h0000_000F);
        check_reg("gpr15_or", 5'd15, 32'h1234_0005);
        check_reg("gpr16_and", 5'd16, 32'h0000_FFFD);
        check_reg("gpr17_slti", 5'd17, 32'd1);

        // ---------------- memory round trip ----------------
        clear_mem();
        put(0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));            // addi $1,$0,5
        put(1, enc_i(6'h2B, 5'd0, 5'd1, 16'h0040));         // sw $1,0x40($0)
        put(2, enc_i(6'h23, 5'd0, 5'd6, 16'h0040));         // lw $6,0x40($0)
        put(3, beq_self);
        put(16, 32'hDEAD_BEEF);
        do_reset();
        check_reg("rf_cleared_by_reset", 5'd3, 32'd0);
        tick(7);                                            // edge 7
        check("sw_before_mem", dut.U_DM.dmem[16], 32'hDEAD_BEEF);
        tick(1);                                            // edge 8
        check("sw_after_mem", dut.U_DM.dmem[16], 32'd5);
        tick(4);                                            // edge 12
        check_reg("lw_before_wb", 5'd6, 32'd0);
        tick(1);                                            // edge 13
        check_reg("lw_after_wb", 5'd6, 32'd5);
        check("lw_pc", dut.PC, 32'd12);

        // ---------------- branch loop ----------------
        clear_mem();
        put(0, enc_i(6'h08, 5'd0, 5'd7, 16'd3));            // addi $7,$0,3
        put(1, enc_i(6'h08, 5'd7, 5'd7, 16'hFFFF));         // loop: addi $7,$7,-1
        put(2, enc_i(6'h05, 5'd7, 5'd0, 16'hFFFE));         // bne $7,$0,loop
        put(3, beq_self);
        do_reset();
        tick(10);                                           // edge 10: bne in ID
        check("bne_id_pc", dut.PC, 32'd12);
        check_reg("loop_iter1", 5'd7, 32'd2);
        tick(1);                                            // edge 11: bne taken
        check("bne_taken_pc", dut.PC, 32'd4);
        tick(14);                                           // edge 25: last bne
        check("bne_not_taken_pc", dut.PC, 32'd12);
        check_reg("loop_done", 5'd7, 32'd0);
        tick(3);                                            // edge 28: beq EX
        check("self_loop_pc", dut.PC, 32'd12);
        check("self_loop_instr", dut.instr, beq_self);
        tick(3);                                            // edge 31
        check("self_loop_parked", dut.PC, 32'd12);

        // ---------------- jump / edge cases ----------------
        clear_mem();
        put(0,    {6'h02, 26'h000_0020});                   // j 0x20
        put(32,   enc_i(6'h08, 5'd0, 5'd0, 16'd7));         // addi $0,$0,7
        put(33,   enc_i(6'h08, 5'd0, 5'd1, 16'd9));         // addi $1,$0,9
        put(34,   enc_i(6'h3F, 5'd1, 5'd1, 16'd1));         // undefined opcode
        put(35,   enc_r(5'd1, 5'd1, 5'd1, 5'd0, 6'h3F));    // undefined funct
        put(36,   beq_self);
        do_reset();
        tick(3);                                            // edge 3: j done
        check("j_pc", dut.PC, 32'h80);
        tick(1);                                            // edge 4
        check("j_target_fetch", dut.instr, enc_i(6'h08, 5'd0, 5'd0, 16'd7));
        tick(9);                                            // edge 13
        check("undef_op_2cyc", dut.PC, 32'h8C);
        tick(2);                                            // edge 15
        check("undef_funct_2cyc", dut.PC, 32'h90);
        tick(20);
        check_reg("gpr0_write_ignored", 5'd0, 32'd0);
        check_reg("gpr1_after_undef", 5'd1, 32'd9);
        check_reg("gpr31_untouched", 5'd31, 32'd0);

        // ---------------- reset during sw S_MEM ----------------
        clear_mem();
        put(0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(1, enc_i(6'h2B, 5'd0, 5'd1, 16'h0040));
        put(2, beq_self);
        put(16, 32'hCAFE_F00D);
        do_reset();
        tick(7);                                            // sw now in S_MEM
        rstn = 1'b1;
        tick(1);
        check("midreset_no_store", dut.U_DM.dmem[16], 32'hCAFE_F00D);
        check("midreset_pc", dut.PC, 32'h0);
        check("midreset_instr", dut.instr, 32'h0);
        rstn = 1'b0;
        tick(1);
        check("midreset_refetch_pc", dut.PC, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
